c_result_writer: RTL and testbench
==================================

Name: c_result_writer

Overview:
- Drains row results from the systolic array's output edge and writes them as 8-bit words into the output-matrix SRAM (sramC port: en, active-low wen, 11-bit addr, 8-bit d).
- Sits directly upstream of sramC.
- Accepts one row of N signed accumulators per handshake and scales/saturates each element to 8 bits.
- Serialises the row into N consecutive SRAM writes at row-major addresses, then signals done after the programmed number of rows.

Parameters:
N, 4, elements (columns) per result row
ACC_W, 20, accumulator width, signed two's complement
SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_W-1)
ROW_STRIDE, 4, address increment between consecutive rows
ADDR_W, 11, SRAM address width
DATA_W, 8, SRAM data width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a job when idle
base_addr  in  ADDR_W  address of element (0,0), latched on start
num_rows  in  8  rows in job, latched on start
psum_valid  in  1  row data valid from array
psum_data  in  N*ACC_W  row; element c at bits [c*ACC_W +: ACC_W]
psum_ready  out  1  writer can accept a row
sram_en  out  1  to sramC en
sram_wen  out  1  to sramC wen, 0 = write
sram_addr  out  ADDR_W  to sramC addr
sram_d  out  DATA_W  to sramC d
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values (async, rst_n=0): state IDLE, psum_ready=0, sram_en=0, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0, all counters 0.
- Reset mid-job aborts immediately: no further writes, and the partial row is discarded.
- All outputs are registered.
- FSM states: IDLE, WAIT_ROW, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr, num_rows; clears row_cnt and col.
  - Next state WAIT_ROW, or DONE if num_rows==0.
  - busy=1 from the cycle after start.
- WAIT_ROW:
  - psum_ready=1.
  - Handshake when psum_valid & psum_ready: the row is captured into an internal N-entry buffer and the state moves to WRITE.
  - psum_ready drops to 0 the cycle after the handshake.
- WRITE: one element per cycle, col = 0..N-1.
  - sram_en=1, sram_wen=0.
  - sram_addr = (row_base + col) mod 2^ADDR_W, where row_base = base_addr + row_cnt*ROW_STRIDE. Address wrap-around is silent.
  - sram_d = sat8(buf[col] >>> SHIFT).
  - After col==N-1: row_cnt increments. Next state is DONE if row_cnt+1==num_rows, else WAIT_ROW.
- Latency: handshake at edge E0 → write 0 presented after E0 and sampled by sramC at E1. Writes land at E1..EN.
- Throughput: one row per N+1 cycles minimum.
- Outside WRITE: sram_en=0 and sram_wen=1. The block never issues reads.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Saturation sat8: signed result clamped to [-128,127].
  - x > 127 → 0x7F.
  - x < -128 → 0x80.
  - Otherwise x[7:0].
  - The shift is arithmetic (sign-extending).
- Ignored inputs:
  - start is ignored unless in IDLE, including start coinciding with done.
  - psum_valid is ignored outside WAIT_ROW; the upstream holds psum_data/psum_valid until ready.
- No writes are ever issued past num_rows rows.

Test Plan:
- Single row: base=0x010, num_rows=1, N=4, row {5,-3,200,-200}, SHIFT=0 → writes at 0x010..0x013 of 0x05, 0xFD, 0x7F, 0x80 on 4 consecutive cycles; done pulses 1 cycle after last write; busy falls.
- Multi-row stride: base=0, num_rows=3, rows all = r+1 → addresses 0..11 in order, data 1,1,1,1,2,…,3; psum_ready high only between rows; exactly 12 writes.
- Shift/saturate: SHIFT=4, element 0x00800 (2048) → 0x7F; element -256 → -16 → 0xF0; element 0x00100 (256) → 0x10.
- Wrap and backpressure: base=0x7FE, num_rows=1, psum_valid delayed 5 cycles → no writes while waiting; writes at 0x7FE, 0x7FF, 0x000, 0x001.
- Edge controls: num_rows=0 → done pulse with no sram_en; start pulsed during WRITE → ignored, write sequence and count unchanged.
- Async reset: rst_n low during the 2nd write of a row → sram_en=0, sram_wen=1 immediately, state IDLE, no done; a new start after release runs a clean job.

Source files
------------

// File: rtl/c_result_writer.sv
// c_result_writer: drains signed accumulator rows from the systolic array's
// output edge, scales/saturates each element to DATA_W bits and writes the
// row as N consecutive words into the output-matrix SRAM (sramC).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                one-cycle pulse, begins a job when idle
//   base_addr, num_rows  job geometry, latched on start
//   psum_valid/ready     row handshake from the array (psum_data = N elements)
//   sram_en/wen/addr/d   sramC write port (wen=0 is write, never reads)
//   busy                 job in progress
//   done                 one-cycle pulse at job end

// Per-element scale: arithmetic shift, then clamp to the signed DATA_W range.
module c_result_writer_lane #(
  parameter int ACC_W  = 20,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 0
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] q
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(1 << (DATA_W-1)));

  logic signed [ACC_W-1:0] sh;
  assign sh = $signed(acc) >>> SHIFT;

  always_comb begin
    q = sh[DATA_W-1:0];
    if (sh > MAXV)      q = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < MINV) q = {1'b1, {(DATA_W-1){1'b0}}};
  end
endmodule

module c_result_writer #(
  parameter int N          = 4,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 0,
  parameter int ROW_STRIDE = 4,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [7:0]          num_rows,
  input  logic                psum_valid,
  input  logic [N*ACC_W-1:0]  psum_data,
  output logic                psum_ready,
  output logic                sram_en,
  output logic                sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_d,
  output logic                busy,
  output logic                done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ROW = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]                   state;
  logic [7:0]                   rows_q;
  logic [7:0]                   row_cnt;
  logic [ADDR_W-1:0]            row_base;  // base_addr + row_cnt*ROW_STRIDE, wraps silently
  logic [CW-1:0]                col;       // element currently on the SRAM port
  logic [N-1:0][DATA_W-1:0]     sat_row;
  logic [N-1:0][DATA_W-1:0]     row_buf;

  // Saturation happens on the incoming row, so the buffer only holds bytes.
  for (genvar g = 0; g < N; g++) begin : g_lane
    c_result_writer_lane #(.ACC_W(ACC_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) u_lane (
      .acc (psum_data[g*ACC_W +: ACC_W]),
      .q   (sat_row[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rows_q     <= '0;
      row_cnt    <= '0;
      row_base   <= '0;
      col        <= '0;
      row_buf    <= '0;
      psum_ready <= 1'b0;
      sram_en    <= 1'b0;
      sram_wen   <= 1'b1;
      sram_addr  <= '0;
      sram_d     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row_base <= base_addr;
          rows_q   <= num_rows;
          row_cnt  <= '0;
          col      <= '0;
          busy     <= 1'b1;
          if (num_rows == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= WAIT_ROW;
            psum_ready <= 1'b1;
          end
        end
        WAIT_ROW: if (psum_valid && psum_ready) begin
          // Element 0 goes straight out on the handshake edge.
          row_buf    <= sat_row;
          psum_ready <= 1'b0;
          sram_en    <= 1'b1;
          sram_wen   <= 1'b0;
          sram_addr  <= row_base;
          sram_d     <= sat_row[0];
          col        <= '0;
          state      <= WRITE;
        end
        WRITE: begin
          if (col == CW'(N-1)) begin
            sram_en  <= 1'b0;
            sram_wen <= 1'b1;
            row_cnt  <= row_cnt + 8'd1;
            row_base <= row_base + ADDR_W'(ROW_STRIDE);
            if (row_cnt + 8'd1 == rows_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= WAIT_ROW;
              psum_ready <= 1'b1;
            end
          end else begin
            col       <= col + CW'(1);
            sram_addr <= row_base + ADDR_W'(col) + ADDR_W'(1);
            sram_d    <= row_buf[col + CW'(1)];
          end
        end
        default: begin  // DONE
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_c_result_writer.sv
// Bench for c_result_writer: dut0 (SHIFT=0) runs most jobs, dut4 (SHIFT=4)
// runs the scaling job. Stimulus pushes expected writes into per-DUT queues;
// a negedge monitor pops and compares whenever sram_en is seen.
module tb_c_result_writer;
  localparam int N = 4, ACC_W = 20, ADDR_W = 11, DATA_W = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start0 = 0, start4 = 0, valid0 = 0, valid4 = 0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        num_rows = '0;
  logic [N*ACC_W-1:0] psum_data = '0;
  logic              ready0, en0, wen0, busy0, done0;
  logic              ready4, en4, wen4, busy4, done4;
  logic [ADDR_W-1:0] addr0, addr4;
  logic [DATA_W-1:0] d0, d4;

  c_result_writer #(.SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base_addr(base_addr), .num_rows(num_rows),
    .psum_valid(valid0), .psum_data(psum_data), .psum_ready(ready0), .sram_en(en0),
    .sram_wen(wen0), .sram_addr(addr0), .sram_d(d0), .busy(busy0), .done(done0));

  c_result_writer #(.SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(base_addr), .num_rows(num_rows),
    .psum_valid(valid4), .psum_data(psum_data), .psum_ready(ready4), .sram_en(en4),
    .sram_wen(wen4), .sram_addr(addr4), .sram_d(d4), .busy(busy4), .done(done4));

  typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  wr_t q0[$], q4[$];
  wr_t e0, e4;
  int total = 0, bad = 0, cyc = 0;
  int wr0 = 0, wr4 = 0, dn0 = 0, dn4 = 0, lastwr0 = 0, lastwr4 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (en0) begin
      wr0++; lastwr0 = cyc;
      chk("wen0", wen0, 0);
      chk("ready_during_write0", ready0, 0);
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write0: got addr %0h data %0h want none", addr0, d0);
      end else begin
        e0 = q0.pop_front();
        chk("addr0", addr0, e0.a);
        chk("data0", d0, e0.d);
      end
    end
    if (en4) begin
      wr4++; lastwr4 = cyc;
      chk("wen4", wen4, 0);
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write4: got addr %0h data %0h want none", addr4, d4);
      end else begin
        e4 = q4.pop_front();
        chk("addr4", addr4, e4.a);
        chk("data4", d4, e4.d);
      end
    end
    if (done0) dn0++;
    if (done4) dn4++;
  end

  function automatic logic [N*ACC_W-1:0] pack(input int a, input int b, input int c, input int d);
    pack = {ACC_W'(d), ACC_W'(c), ACC_W'(b), ACC_W'(a)};
  endfunction

  task automatic push(input bit s4, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.a = a; w.d = d;
    if (s4) q4.push_back(w); else q0.push_back(w);
  endtask

  task automatic start_job(input bit s4, input logic [ADDR_W-1:0] b, input logic [7:0] n);
    base_addr = b; num_rows = n;
    if (s4) start4 = 1; else start0 = 1;
    @(posedge clk); #1;
    start0 = 0; start4 = 0;
    chk("busy_after_start", s4 ? busy4 : busy0, 1);
  endtask

  task automatic drive_row(input bit s4, input logic [N*ACC_W-1:0] data);
    int i = 0;
    bit hs = 0;
    psum_data = data;
    if (s4) valid4 = 1; else valid0 = 1;
    while (!hs && i < 50) begin
      @(negedge clk);
      if (s4 ? ready4 : ready0) hs = 1;
      i++;
    end
    if (!hs) begin
      total++; bad++;
      $display("FAIL handshake_timeout: got ready 0 want 1");
    end else begin
      @(posedge clk); #1;
      chk("first_write_latency", s4 ? en4 : en0, 1);
    end
    valid0 = 0; valid4 = 0;
  endtask

  task automatic wait_done(input bit s4, input bit had_writes);
    int i = 0;
    bit seen = 0;
    while (!seen && i < 60) begin
      @(negedge clk);
      if (s4 ? done4 : done0) seen = 1;
      i++;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      if (had_writes) chk("done_after_last_write", cyc - (s4 ? lastwr4 : lastwr0), 1);
      @(negedge clk);
      chk("busy_falls", s4 ? busy4 : busy0, 0);
      chk("done_one_cycle", s4 ? done4 : done0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dn;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready0, 0);
    chk("rst_en", en0, 0);
    chk("rst_wen", wen0, 1);
    chk("rst_addr", addr0, 0);
    chk("rst_d", d0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_en4", en4, 0);
    rst_n = 1;
    @(negedge clk);

    // single row with saturation at SHIFT=0
    n = wr0;
    start_job(0, 11'h010, 8'd1);
    push(0, 11'h010, 8'h05); push(0, 11'h011, 8'hFD);
    push(0, 11'h012, 8'h7F); push(0, 11'h013, 8'h80);
    drive_row(0, pack(5, -3, 200, -200));
    wait_done(0, 1);
    chk("single_row_count", wr0 - n, 4);

    // three rows, stride 4
    n = wr0;
    start_job(0, 11'h000, 8'd3);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++) push(0, ADDR_W'(r*4 + c), DATA_W'(r + 1));
    for (int r = 0; r < 3; r++) drive_row(0, pack(r+1, r+1, r+1, r+1));
    wait_done(0, 1);
    chk("multi_row_count", wr0 - n, 12);

    // SHIFT=4 instance
    n = wr4;
    start_job(1, 11'h100, 8'd1);
    push(1, 11'h100, 8'h7F); push(1, 11'h101, 8'hF0);
    push(1, 11'h102, 8'h10); push(1, 11'h103, 8'h80);
    drive_row(1, pack(2048, -256, 256, -3000));
    wait_done(1, 1);
    chk("shift_row_count", wr4 - n, 4);

    // address wrap with a late producer
    start_job(0, 11'h7FE, 8'd1);
    push(0, 11'h7FE, 8'd1); push(0, 11'h7FF, 8'd2);
    push(0, 11'h000, 8'd3); push(0, 11'h001, 8'd4);
    n = wr0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_write_while_waiting", wr0 - n, 0);
    chk("ready_while_waiting", ready0, 1);
    drive_row(0, pack(1, 2, 3, 4));
    wait_done(0, 1);
    chk("wrap_count", wr0 - n, 4);

    // zero-row job
    n = wr0;
    start_job(0, 11'h123, 8'd0);
    wait_done(0, 0);
    chk("zero_rows_no_write", wr0 - n, 0);

    // start pulsed mid-row is ignored
    n = wr0;
    start_job(0, 11'h020, 8'd1);
    push(0, 11'h020, 8'd9);  push(0, 11'h021, 8'd10);
    push(0, 11'h022, 8'd11); push(0, 11'h023, 8'd12);
    drive_row(0, pack(9, 10, 11, 12));
    base_addr = 11'h300; num_rows = 8'd5; start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    wait_done(0, 1);
    repeat (8) @(negedge clk);
    chk("start_in_write_count", wr0 - n, 4);
    chk("start_in_write_idle", busy0, 0);

    // async reset during the second write
    n = wr0; dn = dn0;
    start_job(0, 11'h040, 8'd2);
    push(0, 11'h040, 8'd7);
    drive_row(0, pack(7, 8, 9, 10));
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_mid_en", en0, 0);
    chk("rst_mid_wen", wen0, 1);
    chk("rst_mid_busy", busy0, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_count", wr0 - n, 1);
    chk("rst_mid_no_done", dn0 - dn, 0);
    rst_n = 1;
    @(negedge clk);
    n = wr0;
    start_job(0, 11'h050, 8'd1);
    push(0, 11'h050, 8'hFF); push(0, 11'h051, 8'h00);
    push(0, 11'h052, 8'h01); push(0, 11'h053, 8'h7F);
    drive_row(0, pack(-1, 0, 1, 127));
    wait_done(0, 1);
    chk("post_reset_count", wr0 - n, 4);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
